dac_cmd_rx: RTL and testbench
=============================

// Module: dac_cmd_rx
// PURPOSE
//  UART command receiver and 8-channel DAC setpoint bank. Parses framed write
//  commands from the UART receive side, validates them, and stores 12-bit codes
//  in a register bank. DAC_POLLING reads the bank when refreshing the
//  74HC4051-multiplexed channels. Each frame is answered with an ACK/NAK byte
//  on the UART transmit side.
// PARAMETERS
//  N_CH        8        number of DAC channels (address bits = 3)
//  DW          12       DAC code width
//  TIMEOUT     250000   max clk cycles between bytes of one frame (10 ms @ 25 MHz)
//  RESET_CODE  12'd2048 register bank value after reset (mid-scale)
// PORTS
//  clk         in   1    system clock (SYS_CLK, 25 MHz)
//  rst_n       in   1    asynchronous active-low reset
//  rx_data     in   8    received byte from UART (dout)
//  rx_rdy      in   1    UART byte-ready flag, level, held until cleared
//  rdy_clr     out  1    one-cycle pulse clearing UART rx_rdy
//  tx_data     out  8    response byte to UART (din)
//  tx_wr_en    out  1    one-cycle pulse requesting transmission of tx_data
//  tx_busy     in   1    UART transmitter busy
//  rd_addr     in   3    channel read address from DAC_POLLING
//  rd_data     out  DW   registered channel code, 1-cycle latency
//  upd         out  1    one-cycle pulse when a channel register is written
//  upd_ch      out  3    channel written on the upd pulse
//  err_cnt     out  8    count of rejected/timed-out frames, saturates at 255
// BEHAVIOUR
//  Reset: state IDLE; rdy_clr, tx_wr_en, upd = 0; tx_data, upd_ch, err_cnt = 0;
//   all bank entries = RESET_CODE; rd_data = RESET_CODE. Reset mid-frame aborts
//   the frame with no response.
//  Byte acceptance: a byte is accepted on the cycle a registered rising edge of
//   rx_rdy is detected; rdy_clr pulses high in that same cycle. One byte is
//   accepted per rx_rdy edge, never twice.
//  Frame: A5 | CMD | DHI | DLO | CSUM. CMD[7:4]=4'h1 (write), CMD[3]=0, CMD[2:0]
//   = channel. DHI[7:4]=0, DHI[3:0]=code[11:8], DLO=code[7:0].
//   CSUM = CMD ^ DHI ^ DLO.
//  FSM: IDLE -(byte==A5)-> CMD -> DHI -> DLO -> CSUM -> RESP -> IDLE.
//   IDLE discards all bytes other than A5. Each state advances on an accepted byte.
//  CSUM check on the accepted checksum byte: valid = all field rules hold and the
//   checksum matches. Valid: bank[ch] <= code on the next cycle, upd=1, upd_ch=ch,
//   response 8'h5A. Invalid: no write, err_cnt+1, response 8'hEE.
//  RESP: waits while tx_busy=1. When tx_busy=0, pulses tx_wr_en for one cycle
//   with tx_data held valid, then returns to IDLE. Bytes arriving during RESP
//   are accepted (rdy_clr pulses) and dropped.
//  Timeout: the inter-byte counter clears on every accepted byte. In CMD..CSUM,
//   when the counter reaches TIMEOUT-1: go to IDLE, err_cnt+1, no response.
//  Read port: rd_data <= bank[rd_addr] every cycle. A write and a read of the same
//   channel in one cycle return the old value; the new value appears the next cycle.
//  err_cnt: saturates at 255 and does not wrap.
//  A5 inside a frame is treated as data; no resynchronisation occurs mid-frame.
// TESTING
//  Frame A5 13 07 FF EB -> bank[3]=0x7FF; upd pulse with upd_ch=3; tx_data=5A;
//   one tx_wr_en pulse; rd_addr=3 -> rd_data=0x7FF next cycle.
//  Frame A5 12 01 00 00 (bad csum) -> no write, err_cnt=1, tx_data=EE.
//  Bad fields: A5 2x.., A5 1B.., DHI=0x10, each with correct csum -> NAK each,
//   bank unchanged.
//  A5 10 then silence for TIMEOUT cycles -> back in IDLE, err_cnt+1, no tx_wr_en;
//   a following full frame is accepted normally.
//  tx_busy held high for 1000 cycles at the response -> tx_wr_en is delayed until
//   tx_busy falls, exactly one pulse; rx bytes during the wait are dropped.
//  Reset after the A5 13 07 bytes of a frame -> bank all 0x800, err_cnt=0, no
//   response; 300 bad frames -> err_cnt stays 255.

Source files
------------

// File: rtl/dac_cmd_rx.sv
// dac_cmd_rx: UART framed write-command parser feeding an N_CH x DW DAC setpoint bank.
// Answers each complete frame with 5A (accepted) or EE (rejected) on the UART transmit side.
module dac_cmd_rx #(
   parameter int N_CH = 8,
   parameter int DW = 12,
   parameter int TIMEOUT = 250000,
   parameter logic [DW-1:0] RESET_CODE = DW'(2048),
   localparam int AW = $clog2(N_CH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    i_rx_data,
   input  logic          i_rx_rdy,
   output logic          o_rdy_clr,
   output logic [7:0]    o_tx_data,
   output logic          o_tx_wr_en,
   input  logic          i_tx_busy,
   input  logic [AW-1:0] i_rd_addr,
   output logic [DW-1:0] o_rd_data,
   output logic          o_upd,
   output logic [AW-1:0] o_upd_ch,
   output logic [7:0]    o_err_cnt
);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_DHI, S_DLO, S_CSUM, S_RESP} state_t;

   state_t        r_state;
   logic          r_rdy_d1, r_rdy_d2;
   logic [7:0]    r_cmd, r_dhi, r_dlo;
   logic [TW-1:0] r_tmo;
   logic [DW-1:0] r_bank [N_CH];
   logic [7:0]    r_tx_data, r_err_cnt;
   logic          r_tx_wr_en, r_upd;
   logic [DW-1:0] r_rd_data;
   logic [AW-1:0] r_upd_ch;
   logic          w_acc, w_in_frame, w_tmo, w_valid, w_err;

   // Edge of the synchronised ready flag: one acceptance per UART byte even if rx_rdy lingers.
   assign w_acc      = r_rdy_d1 & ~r_rdy_d2;
   assign w_in_frame = (r_state == S_CMD) || (r_state == S_DHI) || (r_state == S_DLO) || (r_state == S_CSUM);
   assign w_tmo      = w_in_frame && !w_acc && (r_tmo == TMAX);
   assign w_valid    = (r_cmd[7:4] == 4'h1) && !r_cmd[3] && (r_dhi[7:4] == 4'h0) &&
                       (i_rx_data == (r_cmd ^ r_dhi ^ r_dlo));
   assign w_err      = w_tmo || (r_state == S_CSUM && w_acc && !w_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rdy_d1   <= 1'b0;
         r_rdy_d2   <= 1'b0;
         r_cmd      <= '0;
         r_dhi      <= '0;
         r_dlo      <= '0;
         r_tmo      <= '0;
         r_tx_data  <= '0;
         r_tx_wr_en <= 1'b0;
         r_upd      <= 1'b0;
         r_upd_ch   <= '0;
         r_err_cnt  <= '0;
         r_rd_data  <= RESET_CODE;
         for (int i = 0; i < N_CH; i++) r_bank[i] <= RESET_CODE;
      end else begin
         r_rdy_d1   <= i_rx_rdy;
         r_rdy_d2   <= r_rdy_d1;
         r_tx_wr_en <= 1'b0;
         r_upd      <= 1'b0;
         r_rd_data  <= r_bank[i_rd_addr];
         r_tmo      <= (w_acc || !w_in_frame) ? '0 : r_tmo + TW'(1);
         if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
         case (r_state)
            S_IDLE: if (w_acc && i_rx_data == 8'hA5) r_state <= S_CMD;
            S_CMD: begin
               if (w_acc) begin
                  r_cmd   <= i_rx_data;
                  r_state <= S_DHI;
               end else if (w_tmo) r_state <= S_IDLE;
            end
            S_DHI: begin
               if (w_acc) begin
                  r_dhi   <= i_rx_data;
                  r_state <= S_DLO;
               end else if (w_tmo) r_state <= S_IDLE;
            end
            S_DLO: begin
               if (w_acc) begin
                  r_dlo   <= i_rx_data;
                  r_state <= S_CSUM;
               end else if (w_tmo) r_state <= S_IDLE;
            end
            S_CSUM: begin
               if (w_acc) begin
                  if (w_valid) begin
                     r_bank[r_cmd[AW-1:0]] <= DW'({r_dhi[3:0], r_dlo});
                     r_upd                 <= 1'b1;
                     r_upd_ch              <= r_cmd[AW-1:0];
                  end
                  r_tx_data <= w_valid ? 8'h5A : 8'hEE;
                  r_state   <= S_RESP;
               end else if (w_tmo) r_state <= S_IDLE;
            end
            S_RESP: begin
               if (!i_tx_busy) begin
                  r_tx_wr_en <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_rdy_clr  = w_acc;
   assign o_tx_data  = r_tx_data;
   assign o_tx_wr_en = r_tx_wr_en;
   assign o_rd_data  = r_rd_data;
   assign o_upd      = r_upd;
   assign o_upd_ch   = r_upd_ch;
   assign o_err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_dac_cmd_rx.sv
// tb_dac_cmd_rx: directed frames for dac_cmd_rx; responses and channel updates go through a scoreboard.
module tb_dac_cmd_rx;
   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  i_rx_data = '0;
   logic        i_rx_rdy = 1'b0;
   logic        o_rdy_clr;
   logic [7:0]  o_tx_data;
   logic        o_tx_wr_en;
   logic        i_tx_busy = 1'b0;
   logic [2:0]  i_rd_addr = '0;
   logic [11:0] o_rd_data;
   logic        o_upd;
   logic [2:0]  o_upd_ch;
   logic [7:0]  o_err_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_tx [$];
   logic [2:0] exp_upd [$];

   dac_cmd_rx #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .i_rx_data(i_rx_data), .i_rx_rdy(i_rx_rdy),
      .o_rdy_clr(o_rdy_clr), .o_tx_data(o_tx_data), .o_tx_wr_en(o_tx_wr_en),
      .i_tx_busy(i_tx_busy), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
      .o_upd(o_upd), .o_upd_ch(o_upd_ch), .o_err_cnt(o_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      bit seen = 0;
      i_rx_data = b;
      i_rx_rdy  = 1'b1;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (o_rdy_clr) seen = 1;
      end
      if (!seen) chk("rdy_clr_timeout", 0, 1);
      @(posedge clk);
      #1 i_rx_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] s);
      send(8'hA5);
      send(c);
      send(h);
      send(l);
      send(s);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [2:0] ch, input logic [11:0] exp);
      i_rd_addr = ch;
      @(posedge clk);
      #1 chk("rd_data", {29'd0, ch, 20'd0} | {20'd0, o_rd_data}, {29'd0, ch, 20'd0} | {20'd0, exp});
   endtask

   always @(negedge clk) begin
      if (o_tx_wr_en) begin
         if (exp_tx.size() == 0) chk("tx_unexpected", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
         else chk("tx_data", {24'd0, o_tx_data}, {24'd0, exp_tx.pop_front()});
         chk("tx_busy_at_wr", {31'd0, i_tx_busy}, 0);
      end
      if (o_upd) begin
         if (exp_upd.size() == 0) chk("upd_unexpected", {29'd0, o_upd_ch}, 32'hFFFF_FFFF);
         else chk("upd_ch", {29'd0, o_upd_ch}, {29'd0, exp_upd.pop_front()});
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_err_cnt", {24'd0, o_err_cnt}, 0);
      chk("rst_tx_data", {24'd0, o_tx_data}, 0);
      chk("rst_upd_ch", {29'd0, o_upd_ch}, 0);
      for (int c = 0; c < 8; c++) rd(3'(c), 12'h800);

      exp_tx.push_back(8'h5A); exp_upd.push_back(3'd3);
      frame(8'h13, 8'h07, 8'hFF, 8'hEB);
      rd(3'd3, 12'h7FF);

      exp_tx.push_back(8'hEE);
      frame(8'h12, 8'h01, 8'h00, 8'h00);
      chk("err_bad_csum", {24'd0, o_err_cnt}, 1);
      rd(3'd2, 12'h800);

      exp_tx.push_back(8'hEE);
      frame(8'h23, 8'h07, 8'hFF, 8'hDB);
      exp_tx.push_back(8'hEE);
      frame(8'h1B, 8'h07, 8'hFF, 8'hE3);
      exp_tx.push_back(8'hEE);
      frame(8'h13, 8'h10, 8'h00, 8'h03);
      chk("err_bad_fields", {24'd0, o_err_cnt}, 4);
      rd(3'd3, 12'h7FF);

      send(8'hA5);
      send(8'h10);
      repeat (TMO + 20) @(posedge clk);
      #1 chk("err_timeout", {24'd0, o_err_cnt}, 5);
      exp_tx.push_back(8'h5A); exp_upd.push_back(3'd0);
      frame(8'h10, 8'h0A, 8'hBC, 8'hA6);
      rd(3'd0, 12'hABC);

      exp_tx.push_back(8'h5A); exp_upd.push_back(3'd5);
      frame(8'h15, 8'h01, 8'hA5, 8'hB1);
      rd(3'd5, 12'h1A5);

      i_tx_busy = 1'b1;
      exp_tx.push_back(8'h5A); exp_upd.push_back(3'd7);
      frame(8'h17, 8'h0F, 8'hFF, 8'hE7);
      send(8'hA5);
      send(8'h13);
      repeat (1000) @(posedge clk);
      #1 chk("tx_held_while_busy", exp_tx.size(), 1);
      i_tx_busy = 1'b0;
      repeat (10) @(posedge clk);
      #1 chk("tx_after_busy", exp_tx.size(), 0);
      rd(3'd7, 12'hFFF);
      exp_tx.push_back(8'h5A); exp_upd.push_back(3'd1);
      frame(8'h11, 8'h00, 8'h55, 8'h44);
      rd(3'd1, 12'h055);
      chk("err_after_busy", {24'd0, o_err_cnt}, 5);

      send(8'hA5);
      send(8'h13);
      send(8'h07);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst2_err_cnt", {24'd0, o_err_cnt}, 0);
      for (int c = 0; c < 8; c++) rd(3'(c), 12'h800);
      send(8'hFF);
      repeat (20) @(posedge clk);
      #1 chk("no_resp_after_rst", exp_tx.size(), 0);

      for (int f = 0; f < 300; f++) begin
         exp_tx.push_back(8'hEE);
         frame(8'h12, 8'h01, 8'h00, 8'h00);
         if (f == 253) chk("err_254", {24'd0, o_err_cnt}, 254);
      end
      chk("err_saturated", {24'd0, o_err_cnt}, 255);
      rd(3'd2, 12'h800);

      repeat (10) @(posedge clk);
      #1 chk("tx_queue_drained", exp_tx.size(), 0);
      chk("upd_queue_drained", exp_upd.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
